// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO behind the UART receiver.
// Captures each rx_valid strobe into a circular buffer and exposes a
// first-word-fall-through read port with level, almost-full and sticky overrun status.
module uart_rx_fifo #(
    parameter int unsigned DEPTH_LOG2  = 4,
    parameter int unsigned AFULL_LEVEL = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    input  logic                  rd_en,
    input  logic                  flush,
    input  logic                  ovr_clr,
    output logic [7:0]            rd_data,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_full,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overrun
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] AFULL_CNT = (DEPTH_LOG2 + 1)'(AFULL_LEVEL);

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  overrun_q, overrun_d;
    logic                  rd_ok, wr_ok, drop;

    // Accept decisions; flush discards both sides of the cycle and never flags a drop.
    always_comb begin
        rd_ok = rd_en && !empty && !flush;
        wr_ok = rx_valid && !flush && (!full || rd_ok);
        drop  = rx_valid && !flush && full && !rd_ok;
    end

    // Next-state for pointers, level counter and sticky overrun.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        overrun_d = overrun_q;
        if (flush) begin
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end else begin
            if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
            if (rd_ok) rd_ptr_d = rd_ptr_q + 1'b1;
            unique case ({wr_ok, rd_ok})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
        // A fresh drop wins over a simultaneous clear.
        if (drop) begin
            overrun_d = 1'b1;
        end else if (ovr_clr) begin
            overrun_d = 1'b0;
        end
    end

    // State registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
        end
    end

    // Storage array, intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr_q] <= rx_data;
    end

    // Status from the registered count only; head byte gated to zero when empty.
    always_comb begin
        count       = count_q;
        overrun     = overrun_q;
        empty       = (count_q == '0);
        full        = (count_q == DEPTH_CNT);
        almost_full = (count_q >= AFULL_CNT);
        rd_data     = empty ? 8'h00 : mem[rd_ptr_q];
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: queue scoreboard of expected bytes,
// popped and compared whenever a read is accepted.
module tb_uart_rx_fifo;

    localparam int DEPTH = 16;
    localparam int AFULL = 12;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rd_en;
    logic       flush;
    logic       ovr_clr;
    logic [7:0] rd_data;
    logic       empty;
    logic       full;
    logic       almost_full;
    logic [4:0] count;
    logic       overrun;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] sb[$];
    logic       ovr_m = 1'b0;

    uart_rx_fifo #(
        .DEPTH_LOG2  (4),
        .AFULL_LEVEL (AFULL)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .rd_en       (rd_en),
        .flush       (flush),
        .ovr_clr     (ovr_clr),
        .rd_data     (rd_data),
        .empty       (empty),
        .full        (full),
        .almost_full (almost_full),
        .count       (count),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_status(input string tag);
        int n;
        n = sb.size();
        check_eq({tag, ".count"}, 32'(count), 32'(n));
        check_eq({tag, ".empty"}, 32'(empty), 32'(n == 0));
        check_eq({tag, ".full"}, 32'(full), 32'(n == DEPTH));
        check_eq({tag, ".afull"}, 32'(almost_full), 32'(n >= AFULL));
        check_eq({tag, ".ovr"}, 32'(overrun), 32'(ovr_m));
        if (n == 0) check_eq({tag, ".rd0"}, 32'(rd_data), 32'h0);
        else        check_eq({tag, ".head"}, 32'(rd_data), 32'(sb[0]));
    endtask

    // One clock cycle of stimulus, entered and left at a negedge.
    task automatic cycle(input string tag, input logic rv, input logic [7:0] d,
                         input logic rd, input logic fl, input logic oc);
        logic       full_m, rdok, wrok, drop;
        logic [7:0] exp;
        full_m = (sb.size() == DEPTH);
        rdok   = !fl && rd && (sb.size() > 0);
        wrok   = !fl && rv && (!full_m || rdok);
        drop   = !fl && rv && !wrok;
        if (rdok) begin
            exp = sb.pop_front();
            check_eq({tag, ".pop"}, 32'(rd_data), 32'(exp));
        end
        rx_valid = rv;
        rx_data  = d;
        rd_en    = rd;
        flush    = fl;
        ovr_clr  = oc;
        @(posedge clk);
        if (fl) sb.delete();
        if (wrok) sb.push_back(d);
        if (drop) ovr_m = 1'b1;
        else if (oc) ovr_m = 1'b0;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        rd_en    = 1'b0;
        flush    = 1'b0;
        ovr_clr  = 1'b0;
        check_status(tag);
    endtask

    task automatic wr(input string tag, input logic [7:0] d);
        cycle(tag, 1'b1, d, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic rd(input string tag);
        cycle(tag, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        int wcnt;
        rst      = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        rd_en    = 1'b0;
        flush    = 1'b0;
        ovr_clr  = 1'b0;

        // Reset held for three cycles, then idle.
        repeat (3) @(negedge clk);
        check_status("in_reset");
        rst = 1'b1;
        for (int i = 0; i < 20; i++) cycle("idle", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        // Basic ordering, plus a read while empty that must be ignored.
        wr("ord", 8'h41);
        wr("ord", 8'h42);
        wr("ord", 8'h43);
        repeat (3) rd("ord");
        rd("rd_empty");

        // Fill, overrun, simultaneous write/read while full, clear priority, drain.
        for (int i = 0; i < 16; i++) wr("fill", 8'(i));
        wr("drop_aa", 8'hAA);
        cycle("wr_rd_full", 1'b1, 8'hBB, 1'b1, 1'b0, 1'b0);
        cycle("clr_vs_drop", 1'b1, 8'hCC, 1'b0, 1'b0, 1'b1);
        cycle("clr_alone", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        repeat (16) rd("drain");

        // Simultaneous write and read while empty: write stored, read ignored.
        cycle("wr_rd_empty", 1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
        rd("drain77");

        // Wrap-around: 40 bytes interleaved 3 writes / 2 reads, then drain.
        wcnt = 0;
        while (wcnt < 40) begin
            for (int k = 0; k < 3 && wcnt < 40; k++) begin
                wr("wrap_w", 8'(8'h60 + wcnt));
                wcnt++;
            end
            repeat (2) rd("wrap_r");
        end
        while (sb.size() > 0) rd("wrap_drain");

        // Set overrun, drain to 5 bytes, then flush alongside a strobe.
        for (int i = 0; i < 16; i++) wr("fill2", 8'(8'h80 + i));
        wr("drop2", 8'hEE);
        repeat (11) rd("to5");
        cycle("flush", 1'b1, 8'h55, 1'b0, 1'b1, 1'b0);

        // Refill three bytes, then an asynchronous reset pulse between edges.
        wr("refill", 8'h11);
        wr("refill", 8'h22);
        wr("refill", 8'h33);
        #2;
        rst = 1'b0;
        #1;
        sb.delete();
        ovr_m = 1'b0;
        check_status("async_rst");
        #1;
        rst = 1'b1;
        @(negedge clk);
        check_status("post_rst");
        wr("after_rst", 8'h5A);
        rd("after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
